sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 1: extra SRAM wait cycles per 16-bit half-access (0..15).
REQ-002 SHALL provide parameter BASE_ADDR, default 1024: byte address mapped to SRAM halfword 0.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 wr_en  input  1  memory-stage write request.
REQ-007 rd_en  input  1  memory-stage read request.
REQ-008 address  input  32  byte address from memory stage.
REQ-009 write_data  input  32  store data.
REQ-010 read_data  output  32  registered load data.
REQ-011 ready  output  1  access complete / idle; pipeline freezes while low.
REQ-012 sram_addr  output  18  SRAM halfword address.
REQ-013 sram_dq_out  output  16  SRAM write data.
REQ-014 sram_dq_in  input  16  SRAM read data.
REQ-015 sram_dq_oe  output  1  drive enable for the DQ pad (1 = drive sram_dq_out).
REQ-016 sram_we_n  output  1  SRAM write strobe, active-low.
REQ-017 sram_oe_n  output  1  SRAM output enable, active-low.
REQ-018 sram_ce_n  output  1  SRAM chip enable, active-low.

Function
REQ-019 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-020 IDLE -> LOW when wr_en|rd_en is sampled high; otherwise remain in IDLE.
REQ-021 LOW and HIGH SHALL each last exactly WAIT_CYCLES+1 cycles, timed by a 4-bit wait counter cleared on every state entry.
REQ-022 LOW -> HIGH -> DONE -> IDLE; DONE SHALL last exactly one cycle.
REQ-023 On the IDLE->LOW edge, SHALL latch operation, word = (address - BASE_ADDR) >> 2, and write_data; later input changes SHALL NOT affect the access in flight.
REQ-024 sram_addr SHALL be {word[16:0],1'b0} in LOW and {word[16:0],1'b1} in HIGH; the subtraction result SHALL be truncated to 18 bits, so the address wraps.
REQ-025 Write: sram_dq_out SHALL be data[15:0] in LOW and data[31:16] in HIGH; sram_dq_oe=1 and sram_we_n=0 in both phases.
REQ-026 Read: sram_oe_n=0 in LOW/HIGH; sram_dq_in SHALL be captured into read_data[15:0] (LOW) or read_data[31:16] (HIGH) on the last cycle of each phase.
REQ-027 sram_ce_n SHALL be 0 in LOW/HIGH and 1 otherwise; outside the active phases, we_n=oe_n=1 and dq_oe=0.
REQ-028 ready = (state==DONE) | (state==IDLE & ~wr_en & ~rd_en), combinational.
REQ-029 Latency: ready SHALL rise 2*WAIT_CYCLES+3 cycles after the request is first sampled in IDLE.
REQ-030 wr_en and rd_en both high SHALL be treated as a write.
REQ-031 A request deasserted mid-access SHALL NOT abort the access; the FSM SHALL complete through DONE.
REQ-032 read_data SHALL hold its value across writes and idle cycles until the next read updates it.

Reset
REQ-033 rst SHALL force state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, and sram_we_n/oe_n/ce_n=1, immediately and independent of clk.
REQ-034 Reset during LOW/HIGH SHALL abandon the access; no further SRAM strobes SHALL follow.

Configuration
REQ-035 Macro SRAM_ACCESS_COUNT_EN, when defined, SHALL add 16-bit outputs rd_count and wr_count, each incremented on DONE of the matching operation, wrapping 0xFFFF->0, and cleared by rst.
REQ-036 Without SRAM_ACCESS_COUNT_EN, those ports and their counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 WAIT_CYCLES=1, wr_en, address=1024, write_data=0xDEADBEEF -> cycles 1-2: sram_addr=0, dq_out=0xBEEF, we_n=0; cycles 3-4: sram_addr=1, dq_out=0xDEAD; ready=1 at cycle 5.
REQ-038 rd_en, address=1024, SRAM model holding the REQ-037 data -> read_data=0xDEADBEEF with ready at cycle 5; read at address 1028 -> sram_addr 2 then 3.
REQ-039 WAIT_CYCLES=0, back-to-back reads with rd_en held high -> ready pulses every 4 cycles, each for one cycle, with no SRAM strobe while in DONE.
REQ-040 wr_en=rd_en=1 at address 1032 -> write strobes on halfwords 4/5; read_data unchanged.
REQ-041 rst asserted in the first HIGH cycle of a write -> we_n=1 and ce_n=1 immediately, state=IDLE, and ready=1 once requests drop.
REQ-042 With SRAM_ACCESS_COUNT_EN: 3 writes then 2 reads -> wr_count=3, rd_count=2; rst -> both 0.

Source files
------------

// File: rtl/sram_controller.sv
`default_nettype none
// sram_controller: 32-bit memory-stage access split into two 16-bit SRAM half-accesses (low, then high).
// Optional macro SRAM_ACCESS_COUNT_EN adds rd_count/wr_count outputs.
module sram_controller #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n
`ifdef SRAM_ACCESS_COUNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [16:0] word_q;
  logic [31:0] data_q;

  logic [31:0] offset_d;
  logic        req_d;
  logic        phase_end_d;
  logic        unused_offset_bits;

  assign offset_d    = address - BASE_ADDR;
  assign req_d       = wr_en | rd_en;
  assign phase_end_d = (cnt_q == WAIT_LAST);
  // Only offset bits [18:2] form the halfword pair index; the rest wrap away.
  assign unused_offset_bits = ^{offset_d[31:19], offset_d[1:0]};

  assign ready = (state_q == DONE) | ((state_q == IDLE) & ~req_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      word_q      <= 17'd0;
      data_q      <= 32'd0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_d) begin
            // A simultaneous read+write request is served as a write.
            state_q     <= LOW;
            cnt_q       <= 4'd0;
            write_q     <= wr_en;
            word_q      <= offset_d[18:2];
            data_q      <= write_data;
            sram_addr   <= {offset_d[18:2], 1'b0};
            sram_dq_out <= wr_en ? write_data[15:0] : 16'd0;
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
            sram_oe_n   <= wr_en;
            sram_ce_n   <= 1'b0;
          end
        end
        LOW: begin
          if (phase_end_d) begin
            state_q     <= HIGH;
            cnt_q       <= 4'd0;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= write_q ? data_q[31:16] : 16'd0;
            if (!write_q) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HIGH: begin
          if (phase_end_d) begin
            state_q    <= DONE;
            cnt_q      <= 4'd0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
            if (!write_q) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

`ifdef SRAM_ACCESS_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (state_q == DONE) begin
      if (write_q) wr_count <= wr_count + 16'd1;
      else         rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// tb_sram_controller: directed vector bench for sram_controller with behavioural SRAM models.
module tb_sram_controller;
  localparam int W = 1;

  logic        clk;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, we_n, oe_n, ce_n;

  logic        wr0, rd0;
  logic [31:0] addr0, wdata0, read_data0;
  logic        ready0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_out0, dq_in0;
  logic        dq_oe0, we_n0, oe_n0, ce_n0;

`ifdef SRAM_ACCESS_COUNT_EN
  logic [15:0] rd_count, wr_count, rd_count0, wr_count0;
`endif

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(dq_out),
    .sram_dq_in(dq_in), .sram_dq_oe(dq_oe), .sram_we_n(we_n),
    .sram_oe_n(oe_n), .sram_ce_n(ce_n)
`ifdef SRAM_ACCESS_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0),
    .address(addr0), .write_data(wdata0), .read_data(read_data0),
    .ready(ready0), .sram_addr(sram_addr0), .sram_dq_out(dq_out0),
    .sram_dq_in(dq_in0), .sram_dq_oe(dq_oe0), .sram_we_n(we_n0),
    .sram_oe_n(oe_n0), .sram_ce_n(ce_n0)
`ifdef SRAM_ACCESS_COUNT_EN
    , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
  );

  // Halfword SRAM model for the main instance; cleared while rst is high.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'd0;
    end else if (!ce_n && !we_n) begin
      mem[sram_addr[7:0]] <= dq_out;
    end
  end
  assign dq_in  = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'd0;
  assign dq_in0 = (!ce_n0 && !oe_n0) ? (sram_addr0[15:0] ^ 16'h5A00) : 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_lo;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic do_access(input vec_t v, input int idx);
    logic        iw, exp_we_n, exp_oe_n, hi;
    logic [17:0] exp_hi;
    iw       = v.wr;
    exp_we_n = !v.wr;
    exp_oe_n = v.wr;
    exp_hi   = v.exp_lo | 18'd1;
    @(negedge clk);
    wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
    #1 chk($sformatf("v%0d_ready_req", idx), {31'd0, ready}, 32'd0);
    for (int c = 1; c <= 2*W+3; c++) begin
      @(negedge clk);
      if (c <= 2*W+2) begin
        hi = (c > W+1);
        chk($sformatf("v%0d_addr_c%0d", idx, c), {14'd0, sram_addr}, {14'd0, hi ? exp_hi : v.exp_lo});
        chk($sformatf("v%0d_ce_n_c%0d", idx, c), {31'd0, ce_n}, 32'd0);
        chk($sformatf("v%0d_we_n_c%0d", idx, c), {31'd0, we_n}, {31'd0, exp_we_n});
        chk($sformatf("v%0d_oe_n_c%0d", idx, c), {31'd0, oe_n}, {31'd0, exp_oe_n});
        chk($sformatf("v%0d_dq_oe_c%0d", idx, c), {31'd0, dq_oe}, {31'd0, iw});
        if (iw) chk($sformatf("v%0d_dq_out_c%0d", idx, c), {16'd0, dq_out},
                    {16'd0, hi ? v.wdata[31:16] : v.wdata[15:0]});
        chk($sformatf("v%0d_ready_busy_c%0d", idx, c), {31'd0, ready}, 32'd0);
      end else begin
        chk($sformatf("v%0d_ready_done", idx), {31'd0, ready}, 32'd1);
        chk($sformatf("v%0d_ce_n_done", idx), {31'd0, ce_n}, 32'd1);
        chk($sformatf("v%0d_we_n_done", idx), {31'd0, we_n}, 32'd1);
        chk($sformatf("v%0d_oe_n_done", idx), {31'd0, oe_n}, 32'd1);
        chk($sformatf("v%0d_read_data", idx), read_data, v.exp_rd);
      end
      // Drop and scramble the request: the access in flight must not notice.
      if (c == 1) begin
        wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_0000; write_data = 32'h0BAD_0BAD;
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", idx), {31'd0, ready}, 32'd1);
    chk($sformatf("v%0d_ce_n_idle", idx), {31'd0, ce_n}, 32'd1);
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [17:0] lo, input logic [31:0] r);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.exp_lo = lo; v.exp_rd = r;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'd0,       32'h0000_0000);
    vecs[1] = mk(1'b0, 1'b1, 32'd1024, 32'h0,        18'd0,       32'hDEADBEEF);
    vecs[2] = mk(1'b1, 1'b0, 32'd1028, 32'h12345678, 18'd2,       32'hDEADBEEF);
    vecs[3] = mk(1'b0, 1'b1, 32'd1028, 32'h0,        18'd2,       32'h12345678);
    vecs[4] = mk(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4,       32'h12345678);
    vecs[5] = mk(1'b0, 1'b1, 32'd1032, 32'h0,        18'd4,       32'hCAFEF00D);
    vecs[6] = mk(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 18'h3FFFE,   32'hCAFEF00D);
    vecs[7] = mk(1'b0, 1'b1, 32'd1020, 32'h0,        18'h3FFFE,   32'hA5A55A5A);

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    wr0 = 1'b0; rd0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_ce_n", {31'd0, ce_n}, 32'd1);
    chk("rst_we_n", {31'd0, we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_out", {16'd0, dq_out}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_ready0", {31'd0, ready0}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 8; i++) do_access(vecs[i], i);

    // Zero-wait instance, read request held high continuously.
    @(negedge clk);
    rd0 = 1'b1; addr0 = 32'd1032;
    #1 chk("b2b_ready_req", {31'd0, ready0}, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), {31'd0, ready0}, {31'd0, (c % 4) == 3});
      chk($sformatf("b2b_ce_n_c%0d", c), {31'd0, ce_n0}, {31'd0, !((c % 4) == 1 || (c % 4) == 2)});
      chk($sformatf("b2b_we_n_c%0d", c), {31'd0, we_n0}, 32'd1);
      if (c == 3) chk("b2b_read_data", read_data0, 32'h5A05_5A04);
    end
    rd0 = 1'b0;
    @(negedge clk);
    chk("b2b_ready_idle", {31'd0, ready0}, 32'd1);

    // Reset in the first HIGH cycle of a write.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h1111_2222;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rh_we_n_high", {31'd0, we_n}, 32'd0);
    chk("rh_addr_high", {14'd0, sram_addr}, 32'd5);
    rst = 1'b1;
    #1;
    chk("rh_we_n", {31'd0, we_n}, 32'd1);
    chk("rh_ce_n", {31'd0, ce_n}, 32'd1);
    chk("rh_dq_oe", {31'd0, dq_oe}, 32'd0);
    chk("rh_read_data", read_data, 32'd0);
    chk("rh_ready", {31'd0, ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rh_ce_n_after_c%0d", c), {31'd0, ce_n}, 32'd1);
      chk($sformatf("rh_ready_after_c%0d", c), {31'd0, ready}, 32'd1);
    end

`ifdef SRAM_ACCESS_COUNT_EN
    chk("cnt_wr_reset", {16'd0, wr_count}, 32'd0);
    chk("cnt_rd_reset", {16'd0, rd_count}, 32'd0);
    do_access(mk(1'b1, 1'b0, 32'd1024, 32'h0000_0001, 18'd0, 32'd0), 10);
    do_access(mk(1'b1, 1'b0, 32'd1028, 32'h0000_0002, 18'd2, 32'd0), 11);
    do_access(mk(1'b1, 1'b0, 32'd1032, 32'h0000_0003, 18'd4, 32'd0), 12);
    do_access(mk(1'b0, 1'b1, 32'd1024, 32'h0,         18'd0, 32'h0000_0001), 13);
    do_access(mk(1'b0, 1'b1, 32'd1028, 32'h0,         18'd2, 32'h0000_0002), 14);
    chk("cnt_wr", {16'd0, wr_count}, 32'd3);
    chk("cnt_rd", {16'd0, rd_count}, 32'd2);
    rst = 1'b1;
    #1;
    chk("cnt_wr_rst", {16'd0, wr_count}, 32'd0);
    chk("cnt_rd_rst", {16'd0, rd_count}, 32'd0);
    @(negedge clk) rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
